// File: rtl/pdp8_ram_arb_if.sv
// Request/done memory port shared by the CPU side, the data-break side and
// the downstream SRAM controller side of pdp8_ram_arb.
// The master drives the strobes, address and write data; the slave answers
// with read data and a completion flag.
interface pdp8_ram_arb_if;
    logic        rd;
    logic        wr;
    logic [14:0] addr;
    logic [11:0] wdata;
    logic [11:0] rdata;
    logic        done;

    modport master (output rd, output wr, output addr, output wdata,
                    input  rdata, input  done);
    modport slave  (input  rd, input  wr, input  addr, input  wdata,
                    output rdata, output done);
endinterface

// File: rtl/pdp8_ram_arb.sv
// pdp8_ram_arb: arbitrates the CPU memory port and the data-break (I/O) port
// onto one SRAM controller port. Data-break requests win over the CPU.
// Optional macro PDP8_ARB_FAIRNESS_EN: after MAX_IO_BURST consecutive I/O
// grants made while the CPU waits, the next grant goes to the CPU.
module pdp8_ram_arb #(
    parameter int MAX_IO_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    pdp8_ram_arb_if.slave  cpu,
    pdp8_ram_arb_if.slave  io,
    pdp8_ram_arb_if.master mem
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IO_ACC  = 2'd1,
        CPU_ACC = 2'd2,
        DONE    = 2'd3
    } state_t;

    if (MAX_IO_BURST < 1 || MAX_IO_BURST > 15) begin : g_burst_range
        $error("pdp8_ram_arb: MAX_IO_BURST must be within 1..15");
    end

    state_t      state_q, state_d;
    logic [14:0] addr_q, addr_d;
    logic [11:0] wdata_q, wdata_d;
    logic        mem_rd_q, mem_rd_d;
    logic        mem_wr_q, mem_wr_d;
    logic        cpu_done_q, cpu_done_d;
    logic        io_done_q, io_done_d;
    logic [11:0] cpu_rdata_q, cpu_rdata_d;
    logic [11:0] io_rdata_q, io_rdata_d;

    logic cpu_req_s;
    logic io_req_s;
    logic cpu_forced_s;
    logic io_grant_s;

    assign cpu_req_s  = cpu.rd | cpu.wr;
    assign io_req_s   = io.rd | io.wr;
    assign io_grant_s = io_req_s & ~cpu_forced_s;

`ifdef PDP8_ARB_FAIRNESS_EN
    localparam logic [3:0] BURST_LIMIT_C = 4'(MAX_IO_BURST);

    logic [3:0] burst_cnt_q, burst_cnt_d;

    assign cpu_forced_s = cpu_req_s & (burst_cnt_q == BURST_LIMIT_C);

    // Count I/O grants that overtake a waiting CPU; any CPU grant or an idle CPU clears it.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE) begin
            if (!cpu_req_s) begin
                burst_cnt_d = 4'd0;
            end else if (io_grant_s) begin
                if (burst_cnt_q < BURST_LIMIT_C) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end else begin
                burst_cnt_d = 4'd0;
            end
        end else begin
            burst_cnt_d = burst_cnt_q;
        end
    end

    // Burst counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt_q <= 4'd0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    assign cpu_forced_s = 1'b0;
`endif

    // Grant, access and completion sequencing; read+write together is a write.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        cpu_done_d  = 1'b0;
        io_done_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        io_rdata_d  = io_rdata_q;
        case (state_q)
            IDLE: begin
                if (io_grant_s) begin
                    addr_d   = io.addr;
                    wdata_d  = io.wdata;
                    mem_wr_d = io.wr;
                    mem_rd_d = ~io.wr;
                    state_d  = IO_ACC;
                end else if (cpu_req_s) begin
                    addr_d   = cpu.addr;
                    wdata_d  = cpu.wdata;
                    mem_wr_d = cpu.wr;
                    mem_rd_d = ~cpu.wr;
                    state_d  = CPU_ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            IO_ACC: begin
                if (mem.done) begin
                    if (mem_rd_q) begin
                        io_rdata_d = mem.rdata;
                    end else begin
                        io_rdata_d = io_rdata_q;
                    end
                    mem_rd_d  = 1'b0;
                    mem_wr_d  = 1'b0;
                    io_done_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = IO_ACC;
                end
            end
            CPU_ACC: begin
                if (mem.done) begin
                    if (mem_rd_q) begin
                        cpu_rdata_d = mem.rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    mem_rd_d   = 1'b0;
                    mem_wr_d   = 1'b0;
                    cpu_done_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = CPU_ACC;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    // State and registered-output flops; reset drops the strobes at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 15'd0;
            wdata_q     <= 12'd0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            cpu_done_q  <= 1'b0;
            io_done_q   <= 1'b0;
            cpu_rdata_q <= 12'd0;
            io_rdata_q  <= 12'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            cpu_done_q  <= cpu_done_d;
            io_done_q   <= io_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.rd    = mem_rd_q;
    assign mem.wr    = mem_wr_q;
    assign cpu.rdata = cpu_rdata_q;
    assign cpu.done  = cpu_done_q;
    assign io.rdata  = io_rdata_q;
    assign io.done   = io_done_q;

endmodule

// File: tb/tb_pdp8_ram_arb.sv
// Scoreboard bench for pdp8_ram_arb: stimulus pushes expected memory accesses
// and done events into queues; a monitor pops and compares them as the DUT
// presents them. Build with PDP8_ARB_FAIRNESS_EN to check the fairness order.
module tb_pdp8_ram_arb;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [14:0] addr;
        logic [11:0] wdata;
    } acc_t;

    typedef struct packed {
        logic        is_io;
        logic [11:0] rdata;
    } done_t;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;
    int   mem_lat;
    int   hi_cnt;
    int   hi_run;
    int   low_run;
    int   last_len;
    int   last_gap;
    logic prev_strobe;
    logic prev_cpu_done;
    logic prev_io_done;

    acc_t  mem_exp[$];
    done_t done_exp[$];
    logic [11:0] ram [int];

    pdp8_ram_arb_if cpu_if();
    pdp8_ram_arb_if io_if();
    pdp8_ram_arb_if mem_if();

    pdp8_ram_arb #(.MAX_IO_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .cpu   (cpu_if),
        .io    (io_if),
        .mem   (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    // SRAM model: completes an access after mem_lat strobe cycles.
    always @(negedge clk) begin
        if (mem_if.rd || mem_if.wr) begin
            hi_cnt = hi_cnt + 1;
            if (hi_cnt == mem_lat) begin
                mem_if.done = 1'b1;
                if (mem_if.wr) begin
                    ram[int'(mem_if.addr)] = mem_if.wdata;
                end else begin
                    mem_if.rdata = ram.exists(int'(mem_if.addr)) ? ram[int'(mem_if.addr)] : 12'o0000;
                end
            end else begin
                mem_if.done = 1'b0;
            end
        end else begin
            hi_cnt = 0;
            mem_if.done = 1'b0;
        end
    end

    // Monitor: compares accesses and done pulses against the scoreboard queues.
    always begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (mem_if.rd || mem_if.wr) begin
                if (!prev_strobe) last_gap = low_run;
                hi_run = hi_run + 1;
                low_run = 0;
                if (mem_if.rd && mem_if.wr) chk("strobe_exclusive", 32'd1, 32'd0);
            end else begin
                if (prev_strobe) last_len = hi_run;
                hi_run = 0;
                low_run = low_run + 1;
            end
            prev_strobe = mem_if.rd | mem_if.wr;
            if (mem_if.done && (mem_if.rd || mem_if.wr)) begin
                if (mem_exp.size() == 0) begin
                    chk("mem_unexpected", 32'd1, 32'd0);
                end else begin
                    acc_t e;
                    e = mem_exp.pop_front();
                    chk("mem_access",
                        {3'b000, mem_if.rd, mem_if.wr, mem_if.addr, (mem_if.wr ? mem_if.wdata : 12'o0000)},
                        {3'b000, e.rd, e.wr, e.addr, (e.wr ? e.wdata : 12'o0000)});
                end
            end
            if (cpu_if.done || io_if.done) begin
                chk("done_exclusive", {31'd0, cpu_if.done & io_if.done}, 32'd0);
                if (cpu_if.done) chk("cpu_done_single", {31'd0, prev_cpu_done}, 32'd0);
                if (io_if.done) chk("io_done_single", {31'd0, prev_io_done}, 32'd0);
                if (done_exp.size() == 0) begin
                    chk("done_unexpected", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = done_exp.pop_front();
                    chk("done_event",
                        {19'd0, io_if.done, (io_if.done ? io_if.rdata : cpu_if.rdata)},
                        {19'd0, d.is_io, d.rdata});
                end
            end
            prev_cpu_done = cpu_if.done;
            prev_io_done = io_if.done;
        end else begin
            prev_strobe = 1'b0;
            prev_cpu_done = 1'b0;
            prev_io_done = 1'b0;
            hi_run = 0;
            low_run = 0;
        end
    end

    // One requester transaction: raise, wait for done, drop on the done cycle.
    task automatic req_txn(input bit is_io, input logic rd, input logic wr,
                           input logic [14:0] addr, input logic [11:0] wdata,
                           input bit scramble, output int cycles);
        bit seen;
        @(negedge clk);
        if (is_io) begin
            io_if.rd = rd; io_if.wr = wr; io_if.addr = addr; io_if.wdata = wdata;
        end else begin
            cpu_if.rd = rd; cpu_if.wr = wr; cpu_if.addr = addr; cpu_if.wdata = wdata;
        end
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 300) begin
            @(negedge clk);
            cycles++;
            if (scramble && cycles == 2) begin
                cpu_if.addr = ~addr;
                cpu_if.wdata = ~wdata;
            end
            seen = is_io ? io_if.done : cpu_if.done;
        end
        if (!seen) chk(is_io ? "io_timeout" : "cpu_timeout", 32'd0, 32'd1);
        if (is_io) begin
            io_if.rd = 1'b0; io_if.wr = 1'b0;
        end else begin
            cpu_if.rd = 1'b0; cpu_if.wr = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int io_cyc;
        int guard;
        n_tests = 0; n_fail = 0;
        mem_lat = 1; hi_cnt = 0; hi_run = 0; low_run = 0;
        last_len = 0; last_gap = 0;
        prev_strobe = 1'b0; prev_cpu_done = 1'b0; prev_io_done = 1'b0;
        cpu_if.rd = 1'b0; cpu_if.wr = 1'b0; cpu_if.addr = 15'o0; cpu_if.wdata = 12'o0;
        io_if.rd = 1'b0; io_if.wr = 1'b0; io_if.addr = 15'o0; io_if.wdata = 12'o0;
        mem_if.done = 1'b0; mem_if.rdata = 12'o0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {30'd0, mem_if.rd, mem_if.wr}, 32'd0);
        chk("rst_dones", {30'd0, cpu_if.done, io_if.done}, 32'd0);
        chk("rst_addr_wdata", {5'd0, mem_if.addr, mem_if.wdata}, 32'd0);
        chk("rst_rdata", {8'd0, cpu_if.rdata, io_if.rdata}, 32'd0);
        reset = 1'b0;

        // CPU read with mem_done three strobe cycles in; address scrambled mid-access.
        ram[int'(15'o01234)] = 12'o7070;
        mem_lat = 3;
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o01234, wdata: 12'o0});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o7070});
        req_txn(1'b0, 1'b1, 1'b0, 15'o01234, 12'o0, 1'b1, cyc);
        chk("cpu_read_latency", cyc, 32'd4);
        repeat (2) @(negedge clk);
        #3;
        chk("cpu_read_strobe_len", last_len, 32'd3);
        chk("cpu_read_data", {20'd0, cpu_if.rdata}, {20'd0, 12'o7070});

        // Simultaneous I/O write and CPU read of the same word: I/O first.
        mem_lat = 1;
        mem_exp.push_back('{rd: 1'b0, wr: 1'b1, addr: 15'o10000, wdata: 12'o4321});
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o10000, wdata: 12'o0});
        done_exp.push_back('{is_io: 1'b1, rdata: 12'o0000});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o4321});
        fork
            req_txn(1'b1, 1'b0, 1'b1, 15'o10000, 12'o4321, 1'b0, io_cyc);
            req_txn(1'b0, 1'b1, 1'b0, 15'o10000, 12'o0, 1'b0, cyc);
        join
        repeat (2) @(negedge clk);
        chk("b2b_gap", last_gap, 32'd2);
        chk("io_rdata_after_write", {20'd0, io_if.rdata}, 32'd0);

        // Continuous I/O writes with a CPU read pending.
        mem_lat = 1;
`ifdef PDP8_ARB_FAIRNESS_EN
        for (int i = 0; i < 4; i++)
            mem_exp.push_back('{rd: 1'b0, wr: 1'b1, addr: 15'(15'o20000 + i), wdata: 12'(12'o1000 + i)});
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o20001, wdata: 12'o0});
        for (int i = 4; i < 6; i++)
            mem_exp.push_back('{rd: 1'b0, wr: 1'b1, addr: 15'(15'o20000 + i), wdata: 12'(12'o1000 + i)});
        for (int i = 0; i < 4; i++) done_exp.push_back('{is_io: 1'b1, rdata: 12'o0000});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o1001});
        for (int i = 4; i < 6; i++) done_exp.push_back('{is_io: 1'b1, rdata: 12'o0000});
`else
        for (int i = 0; i < 6; i++)
            mem_exp.push_back('{rd: 1'b0, wr: 1'b1, addr: 15'(15'o20000 + i), wdata: 12'(12'o1000 + i)});
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o20001, wdata: 12'o0});
        for (int i = 0; i < 6; i++) done_exp.push_back('{is_io: 1'b1, rdata: 12'o0000});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o1001});
`endif
        fork
            begin
                for (int i = 0; i < 6; i++)
                    req_txn(1'b1, 1'b0, 1'b1, 15'(15'o20000 + i), 12'(12'o1000 + i), 1'b0, io_cyc);
            end
            req_txn(1'b0, 1'b1, 1'b0, 15'o20001, 12'o0, 1'b0, cyc);
        join
        repeat (2) @(negedge clk);
        chk("burst_gap", last_gap, 32'd2);
        chk("burst_queue_drained", mem_exp.size(), 32'd0);

        // Reset while a long CPU write is on the bus.
        ram[int'(15'o00100)] = 12'o5252;
        mem_lat = 20;
        @(negedge clk);
        cpu_if.wr = 1'b1; cpu_if.addr = 15'o00100; cpu_if.wdata = 12'o1111;
        guard = 0;
        while (!mem_if.wr && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("rst_mid_wr_seen", {31'd0, mem_if.wr}, 32'd1);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_mid_async_drop", {30'd0, mem_if.rd, mem_if.wr}, 32'd0);
        chk("rst_mid_no_done", {30'd0, cpu_if.done, io_if.done}, 32'd0);
        cpu_if.wr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_rdata", {20'd0, cpu_if.rdata}, 32'd0);
        mem_lat = 2;
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o00100, wdata: 12'o0});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o5252});
        req_txn(1'b0, 1'b1, 1'b0, 15'o00100, 12'o0, 1'b0, cyc);
        chk("post_rst_latency", cyc, 32'd3);

        // CPU asserts read and write together: a write, read data untouched.
        mem_lat = 1;
        mem_exp.push_back('{rd: 1'b0, wr: 1'b1, addr: 15'o00200, wdata: 12'o3333});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o5252});
        req_txn(1'b0, 1'b1, 1'b1, 15'o00200, 12'o3333, 1'b0, cyc);
        mem_exp.push_back('{rd: 1'b1, wr: 1'b0, addr: 15'o00200, wdata: 12'o0});
        done_exp.push_back('{is_io: 1'b0, rdata: 12'o3333});
        req_txn(1'b0, 1'b1, 1'b0, 15'o00200, 12'o0, 1'b0, cyc);

        repeat (4) @(negedge clk);
        chk("mem_queue_empty", mem_exp.size(), 32'd0);
        chk("done_queue_empty", done_exp.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pdp8_ram_arb.md
# pdp8_ram_arb

Memory arbiter between the CPU memory port and the data-break port driven by the I/O subsystem (the `io_ram_*` request/done bundle produced by the RF disk controller). It grants one requester at a time onto the single downstream SRAM controller port, latches the address, data and direction, and returns read data with a one-cycle done pulse. Data-break requests have priority over the CPU. An optional fairness guard bounds how long the CPU can be starved.

## Interface
Parameters:
- `MAX_IO_BURST`, default 4: number of consecutive data-break grants allowed while a CPU request is pending. Used only with `PDP8_ARB_FAIRNESS_EN`. Legal range 1..15.

Ports:
- `clk` in 1: single system clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `cpu_ram_read_req` / `cpu_ram_write_req` in 1: CPU level requests. Each is held until `cpu_ram_done`.
- `cpu_ram_ma` in 15: CPU address (field:addr).
- `cpu_ram_out` in 12: CPU write data.
- `cpu_ram_in` out 12: registered read data for the CPU.
- `cpu_ram_done` out 1: one-cycle completion pulse to the CPU.
- `io_ram_read_req` / `io_ram_write_req` in 1: data-break level requests.
- `io_ram_ma` in 15: data-break address.
- `io_ram_out` in 12: data-break write data.
- `io_ram_in` out 12: registered read data for the I/O side.
- `io_ram_done` out 1: one-cycle completion pulse to the I/O side.
- `mem_addr` out 15: address to the SRAM controller.
- `mem_wdata` out 12: write data to the SRAM controller.
- `mem_rd` / `mem_wr` out 1: strobes, held until `mem_done`.
- `mem_rdata` in 12: SRAM read data, valid in the cycle `mem_done` is high.
- `mem_done` in 1: SRAM completion, any latency of 1 cycle or more.

## Operation
- State machine states: IDLE, IO_ACC, CPU_ACC, DONE.
- **IDLE:** sample requests.
  - If an I/O request is pending, grant I/O. The exception is when fairness is compiled in, a CPU request is pending and `burst_cnt == MAX_IO_BURST`; then grant the CPU.
  - Otherwise, if a CPU request is pending, grant the CPU.
  - On a grant, latch `mem_addr`, `mem_wdata` and the direction into registers, then go to IO_ACC or CPU_ACC.
- **Access states (IO_ACC, CPU_ACC):** drive `mem_rd` or `mem_wr` from the latched direction.
  - Wait for `mem_done`.
  - On `mem_done`, if the access is a read, capture `mem_rdata` into `io_ram_in` or `cpu_ram_in`.
  - Deassert the strobes and go to DONE.
- **DONE:** assert the done pulse for the owner for exactly one cycle, then return to IDLE.
  - The requester drops its request on the same edge, so IDLE sees it cleared.
- **Both read and write asserted by one requester:** treated as a write.
- **Request inputs during an access:** ignored. Address and data changes mid-access have no effect, because the values are latched at grant.
- **Data registers:** `io_ram_in` and `cpu_ram_in` hold their value until the next read completes for that side. Writes leave them unchanged.
- **`burst_cnt` (4 bits):**
  - Increments on each I/O grant made while a CPU request is pending. It saturates at `MAX_IO_BURST`.
  - Clears on any CPU grant.
  - Clears in IDLE when no CPU request is pending.

## Timing
- **Reset values:** state IDLE; `mem_rd`/`mem_wr`/`cpu_ram_done`/`io_ram_done` = 0; `mem_addr`/`mem_wdata`/`cpu_ram_in`/`io_ram_in` = 0; `burst_cnt` = 0.
- **Reset mid-access:** the strobes drop immediately (asynchronously), no done pulse is issued and the pending transaction is abandoned.
- **Latency:**
  - Request seen in IDLE at cycle t.
  - Strobe is high from cycle t+1.
  - With `mem_done` in cycle t+k (k≥1), done is high in cycle t+k+1.
  - Minimum request-to-done is 2 cycles after the grant edge.
- **Back-to-back:** at most one access is in flight. The gap between consecutive accesses is one IDLE cycle.
- **Simultaneous CPU and I/O requests in IDLE:** I/O wins, subject to the fairness rule.
- **Done outputs:** never high in the same cycle as each other, and never high in consecutive cycles for the same side.

## Configuration
- `PDP8_ARB_FAIRNESS_EN` defined:
  - The `burst_cnt` guard is active.
  - After `MAX_IO_BURST` consecutive I/O grants with the CPU waiting, the next grant goes to the CPU.
- Undefined:
  - Strict I/O priority; the CPU can wait indefinitely.
  - `burst_cnt` logic is not synthesized and `MAX_IO_BURST` is unused.

## Test plan
- **CPU read only:** `cpu_ram_ma=15'o01234`, `mem_rdata=12'o7070`, `mem_done` 3 cycles after the strobe → `mem_addr=15'o01234`, `mem_rd` high 3 cycles, `cpu_ram_in=12'o7070`, `cpu_ram_done` single pulse, `io_ram_done` never high.
- **Simultaneous I/O write and CPU read:** I/O write `io_ram_ma=15'o10000`, `io_ram_out=12'o4321` and a CPU read, both in the same cycle → I/O write is issued first with `mem_wdata=12'o4321`; the CPU read follows after one IDLE cycle.
- **Fairness compiled in:** `PDP8_ARB_FAIRNESS_EN`, `MAX_IO_BURST=4`; I/O requests continuously and the CPU read is pending → exactly 4 I/O accesses, then 1 CPU access, then I/O resumes.
- **Fairness compiled out:** same stimulus as the previous scenario without the macro → no CPU grant while the I/O request persists; the CPU is granted within 2 cycles of I/O dropping.
- **Reset mid-access:** `reset` asserted while `mem_wr` is high → `mem_wr` goes low without waiting for a clock edge, no done pulse, state IDLE; after release a new CPU request completes normally.
- **Both directions asserted:** read and write asserted together by the CPU → `mem_wr` is issued, `mem_rd` stays 0, and `cpu_ram_in` is unchanged.
